// File: rtl/ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the true-dual-port RAM (ram_tdp_nc) and its
// read pipeline (ram_rd_pipe).
//   rdw_mode_e   : same-port read-during-write behaviour
//   init_state_e : zero-fill controller states
//   RD_LAT_MAX   : deepest supported read latency
// -----------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST,   // read returns the word before the write
        RDW_WRITE_FIRST,  // read returns the merged word after the write
        RDW_NO_CHANGE     // a writing access issues no read at all
    } rdw_mode_e;

    typedef enum logic {
        INIT,             // zero-fill in progress, port accesses ignored
        READY             // normal operation
    } init_state_e;

    localparam int RD_LAT_MAX = 3;

endpackage : ram_pkg

// File: rtl/ram_rd_pipe.sv
// -----------------------------------------------------------------------------
// ram_rd_pipe
// Delays a read result (valid + data) by STAGES register stages behind the
// RAM output register. Each data stage only loads when its incoming valid is
// set, so the final data output holds its last value between valid pulses.
// STAGES = 0 degenerates to a plain wire.
//
// Ports
//   clk      : clock
//   rst_i    : synchronous active-high reset, clears valid and data stages
//   i_valid  : read result valid from the RAM output register
//   i_data   : read result data from the RAM output register
//   o_valid  : delayed valid (one-cycle pulse per read)
//   o_data   : delayed data, held between pulses
// -----------------------------------------------------------------------------
module ram_rd_pipe #(
    parameter int DATA_BITS = 64,
    parameter int STAGES    = 0
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data
);

    if (STAGES == 0) begin : g_bypass

        // Clock and reset have no work to do without stages.
        logic w_unused;
        assign w_unused = clk ^ rst_i;

        assign o_valid = i_valid;
        assign o_data  = i_data;

    end else begin : g_stages

        logic                 r_valid [STAGES];
        logic [DATA_BITS-1:0] r_data  [STAGES];

        always_ff @(posedge clk) begin
            if (rst_i) begin
                // Flushing the valids discards every read still in flight.
                for (int s = 0; s < STAGES; s++) begin
                    r_valid[s] <= 1'b0;
                    r_data[s]  <= '0;
                end
            end else begin
                r_valid[0] <= i_valid;
                if (i_valid) begin
                    r_data[0] <= i_data;
                end
                for (int s = 1; s < STAGES; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    if (r_valid[s-1]) begin
                        r_data[s] <= r_data[s-1];
                    end
                end
            end
        end

        assign o_valid = r_valid[STAGES-1];
        assign o_data  = r_data[STAGES-1];

    end

endmodule : ram_rd_pipe

// File: rtl/ram_tdp_nc.sv
// -----------------------------------------------------------------------------
// ram_tdp_nc
// True dual-port single-clock RAM with byte write enables, configurable read
// latency, configurable same-port read-during-write behaviour, cross-port
// collision detection and an optional zero-fill of the whole array after
// reset.
//
// Ports
//   clk                     : single clock
//   rst_i                   : synchronous active-high reset
//   a_en / b_en             : access request (ignored while init_busy_o = 1)
//   a_we / b_we             : byte write enables, bit i covers data[8i+7:8i]
//   a_addr / b_addr         : word address
//   a_data_in / b_data_in   : write data
//   a_data_out / b_data_out : read data, held between rvalid pulses
//   a_rvalid_o / b_rvalid_o : one-cycle pulse RD_LAT cycles after a read
//   init_busy_o             : zero-fill in progress
//   collision_o             : pulses the cycle after a same-address access
//                             pair where at least one port writes
//
// Cross-port collisions: bytes written by both ports take port B data, and
// both reads return the word as it was before the edge, whatever RDW_MODE.
// RD_LAT outside 1..RD_LAT_MAX is clamped; DATA_BITS must be a multiple of 8.
// -----------------------------------------------------------------------------
module ram_tdp_nc
    import ram_pkg::*;
#(
    parameter int        ADDR_BITS  = 10,
    parameter int        DATA_BITS  = 64,
    parameter int        RD_LAT     = 1,
    parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST,
    parameter bit        INIT_CLEAR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_i,

    input  logic                   a_en,
    input  logic [DATA_BITS/8-1:0] a_we,
    input  logic [ADDR_BITS-1:0]   a_addr,
    input  logic [DATA_BITS-1:0]   a_data_in,
    output logic [DATA_BITS-1:0]   a_data_out,
    output logic                   a_rvalid_o,

    input  logic                   b_en,
    input  logic [DATA_BITS/8-1:0] b_we,
    input  logic [ADDR_BITS-1:0]   b_addr,
    input  logic [DATA_BITS-1:0]   b_data_in,
    output logic [DATA_BITS-1:0]   b_data_out,
    output logic                   b_rvalid_o,

    output logic                   init_busy_o,
    output logic                   collision_o
);

    localparam int DEPTH    = 2**ADDR_BITS;
    localparam int NB       = DATA_BITS / 8;
    localparam int LAT_EFF  = (RD_LAT < 1) ? 1 :
                              ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    // The RAM output register supplies the first cycle of latency.
    localparam int PIPE_STAGES = LAT_EFF - 1;

    // One bit wider than the address so the last-word compare never wraps.
    localparam logic [ADDR_BITS:0] CNT_LAST = (ADDR_BITS+1)'(DEPTH - 1);

    (* ram_style = "block" *) logic [DATA_BITS-1:0] r_mem [DEPTH];

    init_state_e            r_state;
    logic [ADDR_BITS:0]     r_cnt;
    logic                   r_init_busy;
    logic                   r_collision;

    logic                   r_a_rd_valid;
    logic [DATA_BITS-1:0]   r_a_rd_data;
    logic                   r_b_rd_valid;
    logic [DATA_BITS-1:0]   r_b_rd_data;

    logic                   w_fill_we;
    logic                   w_a_acc;
    logic                   w_b_acc;
    logic                   w_collide;
    logic                   w_a_issue;
    logic                   w_b_issue;
    logic [DATA_BITS-1:0]   w_a_rdata;
    logic [DATA_BITS-1:0]   w_b_rdata;

    // -------------------------------------------------------------------------
    // Access qualification
    // -------------------------------------------------------------------------
    assign w_fill_we = (r_state == INIT) && !rst_i;
    assign w_a_acc   = a_en && !r_init_busy && !rst_i;
    assign w_b_acc   = b_en && !r_init_busy && !rst_i;
    assign w_collide = w_a_acc && w_b_acc && (a_addr == b_addr) &&
                       ((|a_we) || (|b_we));

    // NO_CHANGE suppresses the read of any access that writes.
    assign w_a_issue = w_a_acc && !((RDW_MODE == RDW_NO_CHANGE) && (|a_we));
    assign w_b_issue = w_b_acc && !((RDW_MODE == RDW_NO_CHANGE) && (|b_we));

    // -------------------------------------------------------------------------
    // Init FSM: walks the counter over every word, one per cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst_i) begin
            r_state     <= INIT_CLEAR ? INIT : READY;
            r_cnt       <= '0;
            r_init_busy <= INIT_CLEAR;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= READY;
                        r_init_busy <= 1'b0;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state     <= READY;
                    r_init_busy <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory array write
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch; resetting it would stop it mapping
    // onto block RAM. Clearing is done one word per cycle by the fill above.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[r_cnt[ADDR_BITS-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_a_acc && a_we[i]) begin
                    r_mem[a_addr][8*i +: 8] <= a_data_in[8*i +: 8];
                end
                // Written after port A so B wins bytes both ports write.
                if (w_b_acc && b_we[i]) begin
                    r_mem[b_addr][8*i +: 8] <= b_data_in[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data selection (pre-write word, or merged word for WRITE_FIRST)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        w_a_rdata = r_mem[a_addr];
        w_b_rdata = r_mem[b_addr];
        if ((RDW_MODE == RDW_WRITE_FIRST) && !w_collide) begin
            for (int i = 0; i < NB; i++) begin
                if (a_we[i]) begin
                    w_a_rdata[8*i +: 8] = a_data_in[8*i +: 8];
                end
                if (b_we[i]) begin
                    w_b_rdata[8*i +: 8] = b_data_in[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM output registers and collision flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_a_rd_valid <= 1'b0;
            r_a_rd_data  <= '0;
            r_b_rd_valid <= 1'b0;
            r_b_rd_data  <= '0;
            r_collision  <= 1'b0;
        end else begin
            r_a_rd_valid <= w_a_issue;
            r_b_rd_valid <= w_b_issue;
            r_collision  <= w_collide;
            // Data only loads on a read so it holds between pulses.
            if (w_a_issue) begin
                r_a_rd_data <= w_a_rdata;
            end
            if (w_b_issue) begin
                r_b_rd_data <= w_b_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Remaining read latency, one pipeline per port
    // -------------------------------------------------------------------------
    ram_rd_pipe #(
        .DATA_BITS (DATA_BITS),
        .STAGES    (PIPE_STAGES)
    ) u_a_pipe (
        .clk     (clk),
        .rst_i   (rst_i),
        .i_valid (r_a_rd_valid),
        .i_data  (r_a_rd_data),
        .o_valid (a_rvalid_o),
        .o_data  (a_data_out)
    );

    ram_rd_pipe #(
        .DATA_BITS (DATA_BITS),
        .STAGES    (PIPE_STAGES)
    ) u_b_pipe (
        .clk     (clk),
        .rst_i   (rst_i),
        .i_valid (r_b_rd_valid),
        .i_data  (r_b_rd_data),
        .o_valid (b_rvalid_o),
        .o_data  (b_data_out)
    );

    assign init_busy_o = r_init_busy;
    assign collision_o = r_collision;

endmodule : ram_tdp_nc
